// File: rtl/axi_burst_master_if.sv
// Memory-bus channel bundle between axi_burst_master and the frame-memory slave:
// write address, write data, write response, read address and read data channels.
interface axi_burst_master_if #(
    parameter int ADDR_WIDTH = 32,
    parameter int DATA_WIDTH = 32
);
    logic [ADDR_WIDTH-1:0] awaddr;
    logic [7:0]            awlen;
    logic                  awvalid;
    logic                  awready;

    logic [DATA_WIDTH-1:0] wdata;
    logic                  wvalid;
    logic                  wlast;
    logic                  wready;

    logic [1:0]            bresp;
    logic                  bvalid;
    logic                  bready;

    logic [ADDR_WIDTH-1:0] araddr;
    logic [7:0]            arlen;
    logic                  arvalid;
    logic                  arready;

    logic [DATA_WIDTH-1:0] rdata;
    logic                  rvalid;
    logic                  rlast;
    logic                  rready;

    modport master (
        output awaddr, awlen, awvalid,
        input  awready,
        output wdata, wvalid, wlast,
        input  wready,
        input  bresp, bvalid,
        output bready,
        output araddr, arlen, arvalid,
        input  arready,
        input  rdata, rvalid, rlast,
        output rready
    );

    modport slave (
        input  awaddr, awlen, awvalid,
        output awready,
        input  wdata, wvalid, wlast,
        output wready,
        output bresp, bvalid,
        input  bready,
        input  araddr, arlen, arvalid,
        output arready,
        output rdata, rvalid, rlast,
        input  rready
    );
endinterface

// File: rtl/axi_burst_master.sv
// Single-burst memory initiator: one local command becomes one read or write
// burst on the memory bus. Write beats stream in from wr_*, read beats stream
// out on rd_*, both as combinational pass-through.
// Optional watchdog: define AXI_MASTER_TIMEOUT_EN to abort a burst that sees no
// handshake on its active channel for TIMEOUT_CYCLES cycles.
//
// state   | meaning
// --------+---------------------------------------------------
// IDLE    | waiting for a command; cmd_ready high
// RD_ADDR | presenting araddr/arlen until arready
// RD_DATA | passing read beats from rdata to rd_data
// WR_ADDR | presenting awaddr/awlen until awready
// WR_DATA | passing write beats from wr_data to wdata
// WR_RESP | waiting for the write response
module axi_burst_master #(
    parameter int ADDR_WIDTH = 32,
    parameter int DATA_WIDTH = 32
`ifdef AXI_MASTER_TIMEOUT_EN
    ,
    parameter int TIMEOUT_CYCLES = 1024
`endif
) (
    input  logic                  clk,
    input  logic                  rst,

    input  logic                  cmd_valid,
    output logic                  cmd_ready,
    input  logic                  cmd_write,
    input  logic [ADDR_WIDTH-1:0] cmd_addr,
    input  logic [7:0]            cmd_len,

    input  logic [DATA_WIDTH-1:0] wr_data,
    input  logic                  wr_valid,
    output logic                  wr_ready,

    output logic [DATA_WIDTH-1:0] rd_data,
    output logic                  rd_valid,
    output logic                  rd_last,
    input  logic                  rd_ready,

    output logic                  done,
    output logic                  err,

    axi_burst_master_if.master    bus
);

    typedef enum logic [2:0] {
        IDLE    = 3'd0,
        RD_ADDR = 3'd1,
        RD_DATA = 3'd2,
        WR_ADDR = 3'd3,
        WR_DATA = 3'd4,
        WR_RESP = 3'd5
    } state_t;

    state_t                state_q, state_d;
    logic [ADDR_WIDTH-1:0] addr_q;
    logic [7:0]            len_q;
    logic [7:0]            cnt_q;
    logic                  err_q;
    logic                  done_q;

    logic                  is_last;
    logic                  ar_hs, r_hs, aw_hs, w_hs, b_hs;
    logic                  timeout;

`ifdef AXI_MASTER_TIMEOUT_EN
    localparam logic [15:0] WD_RELOAD = 16'(TIMEOUT_CYCLES - 1);
    logic [15:0]           wd_q;
    logic                  any_hs;
`endif

    assign is_last     = (cnt_q == len_q);
    assign bus.awaddr  = addr_q;
    assign bus.awlen   = len_q;
    assign bus.araddr  = addr_q;
    assign bus.arlen   = len_q;
    assign done        = done_q;
    assign err         = err_q;

    // State register
    always_ff @(posedge clk) begin
        if (rst) state_q <= IDLE;
        else     state_q <= state_d;
    end

    // Next-state, channel handshakes and combinational bus/stream outputs
    always_comb begin
        state_d     = state_q;
        cmd_ready   = 1'b0;
        wr_ready    = 1'b0;
        rd_data     = '0;
        rd_valid    = 1'b0;
        rd_last     = 1'b0;
        bus.awvalid = 1'b0;
        bus.wdata   = '0;
        bus.wvalid  = 1'b0;
        bus.wlast   = 1'b0;
        bus.bready  = 1'b0;
        bus.arvalid = 1'b0;
        bus.rready  = 1'b0;
        ar_hs       = 1'b0;
        r_hs        = 1'b0;
        aw_hs       = 1'b0;
        w_hs        = 1'b0;
        b_hs        = 1'b0;
        timeout     = 1'b0;
`ifdef AXI_MASTER_TIMEOUT_EN
        any_hs      = 1'b0;
`endif
        case (state_q)
            IDLE: begin
                cmd_ready = 1'b1;
                if (cmd_valid) state_d = cmd_write ? WR_ADDR : RD_ADDR;
            end
            RD_ADDR: begin
                bus.arvalid = 1'b1;
                ar_hs       = bus.arready;
                if (ar_hs) state_d = RD_DATA;
            end
            RD_DATA: begin
                bus.rready = rd_ready;
                rd_valid   = bus.rvalid;
                rd_data    = bus.rdata;
                rd_last    = is_last;
                r_hs       = bus.rvalid && rd_ready;
                if (r_hs && is_last) state_d = IDLE;
            end
            WR_ADDR: begin
                bus.awvalid = 1'b1;
                aw_hs       = bus.awready;
                if (aw_hs) state_d = WR_DATA;
            end
            WR_DATA: begin
                bus.wvalid = wr_valid;
                wr_ready   = bus.wready;
                bus.wdata  = wr_data;
                bus.wlast  = is_last;
                w_hs       = wr_valid && bus.wready;
                if (w_hs && is_last) state_d = WR_RESP;
            end
            WR_RESP: begin
                bus.bready = 1'b1;
                b_hs       = bus.bvalid;
                if (b_hs) state_d = IDLE;
            end
            default: state_d = IDLE;
        endcase
`ifdef AXI_MASTER_TIMEOUT_EN
        any_hs  = ar_hs || r_hs || aw_hs || w_hs || b_hs;
        timeout = (state_q != IDLE) && !any_hs && (wd_q == 16'd0);
        if (timeout) state_d = IDLE;
`endif
    end

    // Command capture, beat counting, completion pulse and burst status
    always_ff @(posedge clk) begin
        if (rst) begin
            addr_q <= '0;
            len_q  <= '0;
            cnt_q  <= '0;
            err_q  <= 1'b0;
            done_q <= 1'b0;
        end else begin
            done_q <= 1'b0;
            if (state_q == IDLE && cmd_valid) begin
                addr_q <= cmd_addr;
                len_q  <= cmd_len;
                cnt_q  <= '0;
                err_q  <= 1'b0;
            end
            if (r_hs) begin
                // rlast from the slave must agree with our own beat count
                if (bus.rlast != is_last) err_q <= 1'b1;
                if (is_last) done_q <= 1'b1;
                else         cnt_q  <= cnt_q + 8'd1;
            end
            if (w_hs && !is_last) cnt_q <= cnt_q + 8'd1;
            if (b_hs) begin
                err_q  <= bus.bresp[1];
                done_q <= 1'b1;
            end
            if (timeout) begin
                err_q  <= 1'b1;
                done_q <= 1'b1;
            end
        end
    end

`ifdef AXI_MASTER_TIMEOUT_EN
    // Watchdog down-counter: reloaded in IDLE and on any active-channel handshake
    always_ff @(posedge clk) begin
        if (rst || state_q == IDLE || any_hs) wd_q <= WD_RELOAD;
        else if (wd_q != 16'd0)               wd_q <= wd_q - 16'd1;
    end
`endif

endmodule

// File: tb/tb_axi_burst_master.sv
module tb_axi_burst_master;

    logic        clk = 1'b0;
    logic        rst;
    logic        cmd_valid, cmd_write;
    logic        cmd_ready;
    logic [31:0] cmd_addr;
    logic [7:0]  cmd_len;
    logic [31:0] wr_data;
    logic        wr_valid, wr_ready;
    logic [31:0] rd_data;
    logic        rd_valid, rd_last, rd_ready;
    logic        done, err;

    int vectors    = 0;
    int miscompares = 0;
    int nbeats;

    axi_burst_master_if #(.ADDR_WIDTH(32), .DATA_WIDTH(32)) bus ();

    axi_burst_master #(
        .ADDR_WIDTH(32),
        .DATA_WIDTH(32)
`ifdef AXI_MASTER_TIMEOUT_EN
        ,
        .TIMEOUT_CYCLES(16)
`endif
    ) dut (
        .clk       (clk),
        .rst       (rst),
        .cmd_valid (cmd_valid),
        .cmd_ready (cmd_ready),
        .cmd_write (cmd_write),
        .cmd_addr  (cmd_addr),
        .cmd_len   (cmd_len),
        .wr_data   (wr_data),
        .wr_valid  (wr_valid),
        .wr_ready  (wr_ready),
        .rd_data   (rd_data),
        .rd_valid  (rd_valid),
        .rd_last   (rd_last),
        .rd_ready  (rd_ready),
        .done      (done),
        .err       (err),
        .bus       (bus)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        vectors++;
        assert (obs === exp) else begin
            miscompares++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    initial begin
        #200000;
        $display("FAIL global_timeout: simulation did not finish");
        $fatal(1, "time limit");
    end

    initial begin
        rst = 1'b1; cmd_valid = 0; cmd_write = 0; cmd_addr = 0; cmd_len = 0;
        wr_data = 0; wr_valid = 0; rd_ready = 0;
        bus.awready = 0; bus.wready = 0; bus.bresp = 0; bus.bvalid = 0;
        bus.arready = 0; bus.rdata = 0; bus.rvalid = 0; bus.rlast = 0;

        // ---------- reset state ----------
        repeat (2) @(negedge clk);
        rst = 1'b0; #1;
        chk("rst_cmd_ready", cmd_ready, 1);
        chk("rst_arvalid", bus.arvalid, 0);
        chk("rst_awvalid", bus.awvalid, 0);
        chk("rst_wvalid", bus.wvalid, 0);
        chk("rst_rready", bus.rready, 0);
        chk("rst_bready", bus.bready, 0);
        chk("rst_done", done, 0);
        chk("rst_err", err, 0);
        chk("rst_rd_valid", rd_valid, 0);

        // ---------- read 0x10, len 3 ----------
        @(negedge clk); cmd_valid = 1; cmd_write = 0; cmd_addr = 32'h10; cmd_len = 3; #1;
        chk("r1_arvalid_idle", bus.arvalid, 0);
        @(negedge clk); cmd_valid = 0; #1;
        chk("r1_arvalid", bus.arvalid, 1);
        chk("r1_araddr", bus.araddr, 32'h10);
        chk("r1_arlen", bus.arlen, 3);
        chk("r1_cmd_ready_busy", cmd_ready, 0);
        @(negedge clk); bus.arready = 1; #1;
        chk("r1_arvalid_held", bus.arvalid, 1);
        chk("r1_araddr_held", bus.araddr, 32'h10);
        @(negedge clk); bus.arready = 0; rd_ready = 1; bus.rvalid = 1;
        for (int i = 0; i < 4; i++) begin
            if (i > 0) @(negedge clk);
            bus.rdata = 32'hA0 + i; bus.rlast = (i == 3); #1;
            chk("r1_rd_valid", rd_valid, 1);
            chk("r1_rd_data", rd_data, 32'hA0 + i);
            chk("r1_rd_last", rd_last, (i == 3));
            chk("r1_rready", bus.rready, 1);
            chk("r1_done_early", done, 0);
        end
        @(negedge clk); bus.rvalid = 0; bus.rlast = 0; rd_ready = 0; #1;
        chk("r1_done", done, 1);
        chk("r1_err", err, 0);
        chk("r1_cmd_ready", cmd_ready, 1);
        @(negedge clk); #1;
        chk("r1_done_pulse", done, 0);

        // ---------- write 0x20, len 7 ----------
        @(negedge clk); cmd_valid = 1; cmd_write = 1; cmd_addr = 32'h20; cmd_len = 7;
        wr_valid = 1; wr_data = 32'h0; bus.wready = 1; #1;
        chk("w1_wvalid_idle", bus.wvalid, 0);
        @(negedge clk); cmd_valid = 0; bus.awready = 1; #1;
        chk("w1_awvalid", bus.awvalid, 1);
        chk("w1_awaddr", bus.awaddr, 32'h20);
        chk("w1_awlen", bus.awlen, 7);
        chk("w1_wvalid_addr", bus.wvalid, 0);
        chk("w1_wr_ready_addr", wr_ready, 0);
        for (int i = 0; i < 8; i++) begin
            @(negedge clk); bus.awready = 0; wr_data = 32'hB0 + i; #1;
            chk("w1_wvalid", bus.wvalid, 1);
            chk("w1_wdata", bus.wdata, 32'hB0 + i);
            chk("w1_wlast", bus.wlast, (i == 7));
            chk("w1_wr_ready", wr_ready, 1);
            chk("w1_bready_data", bus.bready, 0);
        end
        @(negedge clk); wr_valid = 0; #1;
        chk("w1_bready", bus.bready, 1);
        chk("w1_wvalid_resp", bus.wvalid, 0);
        @(negedge clk); bus.bvalid = 1; bus.bresp = 2'b00; #1;
        chk("w1_bready2", bus.bready, 1);
        @(negedge clk); bus.bvalid = 0; #1;
        chk("w1_done", done, 1);
        chk("w1_err", err, 0);
        chk("w1_cmd_ready", cmd_ready, 1);
        chk("w1_bready_idle", bus.bready, 0);

        // ---------- read 0x40, len 3, rd_ready toggling ----------
        @(negedge clk); cmd_valid = 1; cmd_write = 0; cmd_addr = 32'h40; cmd_len = 3; bus.wready = 0;
        @(negedge clk); cmd_valid = 0; bus.arready = 1; #1;
        chk("r2_arvalid", bus.arvalid, 1);
        @(negedge clk); bus.arready = 0; bus.rvalid = 1;
        nbeats = 0;
        for (int c = 0; c < 7; c++) begin
            if (c > 0) @(negedge clk);
            rd_ready = (c % 2 == 0);
            bus.rdata = 32'hC0 + nbeats; bus.rlast = (nbeats == 3); #1;
            chk("r2_rready", bus.rready, (c % 2 == 0));
            chk("r2_rd_data", rd_data, 32'hC0 + nbeats);
            chk("r2_rd_last", rd_last, (nbeats == 3));
            if (rd_valid && rd_ready) nbeats++;
        end
        @(negedge clk); rd_ready = 1; #1;
        chk("r2_beats", nbeats, 4);
        chk("r2_done", done, 1);
        chk("r2_err", err, 0);
        chk("r2_rready_idle", bus.rready, 0);
        chk("r2_rd_valid_idle", rd_valid, 0);
        bus.rvalid = 0; bus.rlast = 0; rd_ready = 0;

        // ---------- write len 0 with SLVERR ----------
        @(negedge clk); cmd_valid = 1; cmd_write = 1; cmd_addr = 32'h30; cmd_len = 0;
        @(negedge clk); cmd_valid = 0; bus.awready = 1; #1;
        chk("w2_awvalid", bus.awvalid, 1);
        chk("w2_awlen", bus.awlen, 0);
        @(negedge clk); bus.awready = 0; bus.wready = 1; wr_valid = 1; wr_data = 32'hDEAD; #1;
        chk("w2_wvalid", bus.wvalid, 1);
        chk("w2_wlast", bus.wlast, 1);
        chk("w2_wdata", bus.wdata, 32'hDEAD);
        @(negedge clk); wr_valid = 0; bus.wready = 0; bus.bvalid = 1; bus.bresp = 2'b10; #1;
        chk("w2_bready", bus.bready, 1);
        @(negedge clk); bus.bvalid = 0; bus.bresp = 2'b00; #1;
        chk("w2_done", done, 1);
        chk("w2_err", err, 1);
        chk("w2_cmd_ready", cmd_ready, 1);
        @(negedge clk); #1;
        chk("w2_cmd_ready_next", cmd_ready, 1);
        chk("w2_done_pulse", done, 0);

        // ---------- read len 1, rlast early -> err ----------
        @(negedge clk); cmd_valid = 1; cmd_write = 0; cmd_addr = 32'h44; cmd_len = 1;
        @(negedge clk); cmd_valid = 0; bus.arready = 1;
        @(negedge clk); bus.arready = 0; rd_ready = 1; bus.rvalid = 1; bus.rdata = 32'h1; bus.rlast = 1; #1;
        chk("r3_rd_last0", rd_last, 0);
        @(negedge clk); bus.rdata = 32'h2; bus.rlast = 0; #1;
        chk("r3_rd_last1", rd_last, 1);
        @(negedge clk); bus.rvalid = 0; rd_ready = 0; #1;
        chk("r3_done", done, 1);
        chk("r3_err", err, 1);

        // ---------- reset during RD_DATA beat 2 ----------
        @(negedge clk); cmd_valid = 1; cmd_write = 0; cmd_addr = 32'h50; cmd_len = 3;
        @(negedge clk); cmd_valid = 0; bus.arready = 1;
        @(negedge clk); bus.arready = 0; rd_ready = 1; bus.rvalid = 1; bus.rlast = 0; bus.rdata = 32'h50;
        @(negedge clk); bus.rdata = 32'h51;
        @(negedge clk); bus.rdata = 32'h52; rst = 1; #1;
        chk("rs_rd_valid_before", rd_valid, 1);
        @(negedge clk); rst = 0; #1;
        chk("rs_rd_valid", rd_valid, 0);
        chk("rs_rready", bus.rready, 0);
        chk("rs_arvalid", bus.arvalid, 0);
        chk("rs_cmd_ready", cmd_ready, 1);
        chk("rs_done", done, 0);
        bus.rvalid = 0;
        @(negedge clk); cmd_valid = 1; cmd_write = 0; cmd_addr = 32'h60; cmd_len = 0;
        @(negedge clk); cmd_valid = 0; bus.arready = 1; #1;
        chk("rs_arvalid2", bus.arvalid, 1);
        chk("rs_araddr2", bus.araddr, 32'h60);
        @(negedge clk); bus.arready = 0; bus.rvalid = 1; bus.rlast = 1; bus.rdata = 32'h77; #1;
        chk("rs_rd_last", rd_last, 1);
        chk("rs_rd_data", rd_data, 32'h77);
        @(negedge clk); bus.rvalid = 0; bus.rlast = 0; rd_ready = 0; #1;
        chk("rs_done2", done, 1);
        chk("rs_err2", err, 0);

`ifdef AXI_MASTER_TIMEOUT_EN
        // ---------- watchdog: awready stuck low ----------
        @(negedge clk); cmd_valid = 1; cmd_write = 1; cmd_addr = 32'h70; cmd_len = 2;
        for (int i = 0; i < 16; i++) begin
            @(negedge clk); cmd_valid = 0; #1;
            chk("to_awvalid", bus.awvalid, 1);
            chk("to_done_early", done, 0);
        end
        @(negedge clk); #1;
        chk("to_done", done, 1);
        chk("to_err", err, 1);
        chk("to_awvalid_drop", bus.awvalid, 0);
        chk("to_cmd_ready", cmd_ready, 1);
`endif

        @(negedge clk);
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
